resp_checker: RTL



---
 rtl/resp_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/resp_checker.sv
// Response analyser: masked compare of CUT responses against expected values,
// with mismatch counting, first-fail capture and MISR signature compaction.
module resp_checker #(
    parameter int               W     = 1,
    parameter int               CNT_W = 16,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             abort,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [W-1:0]     resp,
    input  logic [W-1:0]     exp,
    input  logic [W-1:0]     mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pat_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [SIG_W-1:0] inject;
    logic [SIG_W-1:0] sig_next;
    logic             mismatch;
    logic             accept;
    logic             last_pat;

    // Masked response bits are zero-extended into the MISR width.
    always_comb begin
        inject         = '0;
        inject[W-1:0]  = resp & mask;
    end

    assign sig_next   = {signature[SIG_W-2:0], 1'b0}
                      ^ (signature[SIG_W-1] ? POLY : '0)
                      ^ inject;
    assign mismatch   = |((resp ^ exp) & mask);
    assign accept     = (state == RUN) && resp_valid;
    assign last_pat   = (pat_cnt == target - CNT_W'(1));
    assign resp_ready = (state == RUN);
    assign pass       = (fail_cnt == '0);

    // Abort outranks a same-cycle accept so results freeze at what was already taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            target         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pat_cnt        <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            signature      <= SEED;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_cnt        <= '0;
                        fail_cnt       <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        signature      <= SEED;
                        target         <= num_pat;
                        busy           <= 1'b1;
                        if (num_pat == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        pat_cnt   <= pat_cnt + CNT_W'(1);
                        signature <= sig_next;
                        if (mismatch) begin
                            if (fail_cnt != '1) begin
                                fail_cnt <= fail_cnt + CNT_W'(1);
                            end
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_idx <= pat_cnt;
                            end
                        end
                        if (last_pat) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
